// File: rtl/instruction_mem_loader_pkg.sv
// Shared constants for the instruction-memory loader: byte/word geometry, FSM encoding, length clamp.
package instruction_mem_loader_pkg;

  localparam int BYTE_W        = 8;
  localparam int WORD_BYTES    = 4;
  localparam int WORD_W        = BYTE_W * WORD_BYTES;
  localparam int IM_ADDR_SHIFT = 2;
  localparam int LEN_W         = 9;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len, input int max_words);
    return (int'(len) > max_words) ? LEN_W'(max_words) : len;
  endfunction

endpackage

// File: rtl/instruction_mem_loader_if.sv
// Host byte link plus IM write port of the loader; master = host/IM side, slave = loader.
interface instruction_mem_loader_if;
  import instruction_mem_loader_pkg::*;

  logic              START_IL;
  logic [LEN_W-1:0]  LEN_IL;
  logic [BYTE_W-1:0] DATA_IL;
  logic              VALID_IL;
  logic              READY_IL;
  logic              WE_IM;
  logic [WORD_W-1:0] WA_IM;
  logic [WORD_W-1:0] WD_IM;
  logic              BUSY_IL;
  logic              DONE_IL;
  logic              ERR_IL;

  modport master (
    output START_IL, LEN_IL, DATA_IL, VALID_IL,
    input  READY_IL, WE_IM, WA_IM, WD_IM, BUSY_IL, DONE_IL, ERR_IL
  );

  modport slave (
    input  START_IL, LEN_IL, DATA_IL, VALID_IL,
    output READY_IL, WE_IM, WA_IM, WD_IM, BUSY_IL, DONE_IL, ERR_IL
  );

endinterface

// File: rtl/instruction_mem_loader_word_assembler.sv
// Packs four stream bytes into a little-endian word; o_word already includes the byte on i_byte.
module instruction_mem_loader_word_assembler
  import instruction_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_shift,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_full
);

  localparam int CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0]         r_cnt;
  // Only the three older bytes need storage; the newest arrives on i_byte.
  logic [WORD_W-BYTE_W-1:0] r_sr;

  assign o_word = {i_byte, r_sr};
  assign o_full = i_shift && (r_cnt == CNT_W'(WORD_BYTES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (i_shift) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_sr  <= o_word[WORD_W-1:BYTE_W];
    end
  end

endmodule

// File: rtl/instruction_mem_loader.sv
// Byte-stream to IM word writer with FSM and word index. Optional trailing XOR checksum word
// is enabled by defining LOADER_CHECKSUM_EN.
module instruction_mem_loader
  import instruction_mem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  instruction_mem_loader_if.slave    bus
);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [LEN_W-1:0]  w_len_clamped;
  logic [WORD_W-1:0] r_wa;
  logic [WORD_W-1:0] r_wd;
  logic [WORD_W-1:0] w_word;
  logic              w_start;
  logic              w_ready;
  logic              w_take;
  logic              w_full;
  logic              w_last_word;

  assign w_start       = bus.START_IL && (r_state == ST_IDLE);
  assign w_len_clamped = clamp_len(bus.LEN_IL, MAX_WORDS);
`ifdef LOADER_CHECKSUM_EN
  assign w_ready       = (r_state == ST_COLLECT) || (r_state == ST_CHECK);
`else
  assign w_ready       = (r_state == ST_COLLECT);
`endif
  assign w_take        = w_ready && bus.VALID_IL;
  assign w_last_word   = (r_idx + LEN_W'(1)) == r_len;

  instruction_mem_loader_word_assembler u_asm (
    .clk     (CLK),
    .rst_n   (RST_N),
    .i_clear (w_start),
    .i_shift (w_take),
    .i_byte  (bus.DATA_IL),
    .o_word  (w_word),
    .o_full  (w_full)
  );

  always_comb begin
    // NOTE: default first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_start) w_state_nxt = (w_len_clamped == '0) ? ST_FINISH : ST_COLLECT;
      ST_COLLECT: if (w_full)  w_state_nxt = ST_WRITE;
`ifdef LOADER_CHECKSUM_EN
      ST_WRITE:   w_state_nxt = w_last_word ? ST_CHECK : ST_COLLECT;
      ST_CHECK:   if (w_full)  w_state_nxt = ST_FINISH;
`else
      ST_WRITE:   w_state_nxt = w_last_word ? ST_FINISH : ST_COLLECT;
`endif
      ST_FINISH:  w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_wa    <= '0;
      r_wd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_len <= w_len_clamped;
        r_idx <= '0;
      end
      // Address/data are captured with the 4th byte so WRITE presents them with no extra cycle.
      if ((r_state == ST_COLLECT) && w_full) begin
        r_wa <= BASE_ADDR + (WORD_W'(r_idx) << IM_ADDR_SHIFT);
        r_wd <= w_word;
      end
      if (r_state == ST_WRITE) r_idx <= r_idx + LEN_W'(1);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] r_csum;
  logic              r_err;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_csum <= '0;
      r_err  <= 1'b0;
    end else if (w_start) begin
      r_csum <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == ST_WRITE) r_csum <= r_csum ^ r_wd;
      if ((r_state == ST_CHECK) && w_full && (w_word != r_csum)) r_err <= 1'b1;
    end
  end

  assign bus.ERR_IL = r_err;
`else
  assign bus.ERR_IL = 1'b0;
`endif

  assign bus.READY_IL = w_ready;
  assign bus.WE_IM    = (r_state == ST_WRITE);
  assign bus.WA_IM    = r_wa;
  assign bus.WD_IM    = r_wd;
  assign bus.BUSY_IL  = (r_state == ST_COLLECT) || (r_state == ST_WRITE) || (r_state == ST_CHECK);
  assign bus.DONE_IL  = (r_state == ST_FINISH);

endmodule

// File: tb/tb_instruction_mem_loader.sv
// Self-checking bench for instruction_mem_loader: directed and random loads against a word-list model.
module tb_instruction_mem_loader;
  import instruction_mem_loader_pkg::*;

  localparam int MAXW = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  instruction_mem_loader_if bus ();

  instruction_mem_loader dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  int          cyc = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          done_cnt    = 0;
  int          done_cyc    = -1;
  int          last_we_cyc = -1;
  int          ready_viol  = 0;
  int          busy_viol   = 0;
  logic [7:0]  stim[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    if (bus.WE_IM) begin
      wa_q.push_back(bus.WA_IM);
      wd_q.push_back(bus.WD_IM);
      last_we_cyc <= cyc;
      if (bus.READY_IL) ready_viol <= ready_viol + 1;
    end
    if (bus.DONE_IL) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      if (bus.BUSY_IL) busy_viol <= busy_viol + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the byte has been taken.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit taken = 1'b0;
    for (int g = 0; g < 100 && !taken; g++) begin
      bus.DATA_IL  = b;
      bus.VALID_IL = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.START_IL = stall && ($urandom_range(0, 4) == 0);
      if (bus.START_IL) bus.LEN_IL = 9'($urandom_range(0, 511));
      taken = bus.VALID_IL && bus.READY_IL;
      @(negedge clk);
    end
    bus.VALID_IL = 1'b0;
    bus.START_IL = 1'b0;
    if (!taken) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)), stall);
  endtask

  task automatic fill_random(input int words);
    stim.delete();
    for (int i = 0; i < 4 * words; i++) stim.push_back(8'($urandom));
  endtask

  // One complete load of stim[]; the model is the list of little-endian words at BASE+4*i.
  task automatic run_load(input string name, input int len, input bit stall, input bit bad_csum);
    int          n;
    logic [31:0] exp_wd[$];
    logic [31:0] xr;
    logic [31:0] csum_word;
    logic        exp_err;
    int          scyc;
    n  = (len > MAXW) ? MAXW : len;
    xr = '0;
    for (int i = 0; i < n; i++) begin
      exp_wd.push_back({stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]});
      xr = xr ^ exp_wd[i];
    end
    csum_word = bad_csum ? 32'h0 : xr;
    exp_err   = 1'b0;

    @(posedge clk);
    wa_q.delete();
    wd_q.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    ready_viol = 0;
    busy_viol  = 0;

    @(negedge clk);
    bus.START_IL = 1'b1;
    bus.LEN_IL   = 9'(len);
    scyc         = cyc;
    @(negedge clk);
    bus.START_IL = 1'b0;
    bus.LEN_IL   = 9'($urandom);
    if (n > 0) check({name, "_busy"}, 32'(bus.BUSY_IL), 32'd1);

    for (int i = 0; i < 4 * n; i++) send_byte(stim[i], stall);
`ifdef LOADER_CHECKSUM_EN
    if (n > 0) begin
      send_word(csum_word, stall);
      exp_err = (csum_word != xr);
    end
`endif

    for (int t = 0; t < 50 && done_cnt == 0; t++) @(posedge clk);
    repeat (4) @(negedge clk);
    @(posedge clk);

    check({name, "_done_count"}, 32'(done_cnt), 32'd1);
    check({name, "_we_count"}, 32'(wa_q.size()), 32'(n));
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      check($sformatf("%s_wa%0d", name, i), wa_q[i], 32'h0 + 32'(4 * i));
      check($sformatf("%s_wd%0d", name, i), wd_q[i], exp_wd[i]);
    end
    check({name, "_ready_in_write"}, 32'(ready_viol), 32'd0);
    check({name, "_busy_at_done"}, 32'(busy_viol), 32'd0);
    check({name, "_err"}, 32'(bus.ERR_IL), 32'(exp_err));
    // DONE lands on the cycle after START (empty load) or after the last WE.
    if (n == 0)
      check({name, "_done_latency"}, 32'(done_cyc), 32'(scyc + 1));
`ifndef LOADER_CHECKSUM_EN
    else
      check({name, "_done_after_we"}, 32'(done_cyc), 32'(last_we_cyc + 1));
`endif
  endtask

  initial begin
    bus.START_IL = 1'b0;
    bus.LEN_IL   = '0;
    bus.DATA_IL  = '0;
    bus.VALID_IL = 1'b0;

    // Reset state
    #1;
    check("rst_ready", 32'(bus.READY_IL), 32'd0);
    check("rst_we",    32'(bus.WE_IM),    32'd0);
    check("rst_busy",  32'(bus.BUSY_IL),  32'd0);
    check("rst_done",  32'(bus.DONE_IL),  32'd0);
    check("rst_err",   32'(bus.ERR_IL),   32'd0);
    check("rst_wa",    bus.WA_IM,         32'd0);
    check("rst_wd",    bus.WD_IM,         32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-word load
    stim = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h00, 8'h00};
    run_load("t2", 2, 1'b0, 1'b0);

    // Same data with random VALID gaps and stray START pulses
    run_load("t3", 2, 1'b1, 1'b0);

    // Reset mid-COLLECT after two bytes, then a clean single-word load
    @(negedge clk);
    bus.START_IL = 1'b1;
    bus.LEN_IL   = 9'd2;
    @(negedge clk);
    bus.START_IL = 1'b0;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t1_rst_ready", 32'(bus.READY_IL), 32'd0);
    check("t1_rst_we",    32'(bus.WE_IM),    32'd0);
    check("t1_rst_busy",  32'(bus.BUSY_IL),  32'd0);
    check("t1_rst_done",  32'(bus.DONE_IL),  32'd0);
    check("t1_rst_err",   32'(bus.ERR_IL),   32'd0);
    check("t1_rst_wa",    bus.WA_IM,         32'd0);
    check("t1_rst_wd",    bus.WD_IM,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stim = '{8'h13, 8'h00, 8'h00, 8'h00};
    run_load("t1", 1, 1'b0, 1'b0);

    // Empty load and clamped oversize load
    stim.delete();
    run_load("t4_len0", 0, 1'b0, 1'b0);
    fill_random(MAXW);
    run_load("t4_len300", 300, 1'b0, 1'b0);
    check("t4_last_wa", (wa_q.size() == MAXW) ? wa_q[MAXW-1] : 32'hFFFF_FFFF, 32'h0000_03FC);

    // Random lengths, data and stalls
    for (int r = 0; r < 4; r++) begin
      int len;
      len = $urandom_range(1, 12);
      fill_random(len);
      run_load($sformatf("rnd%0d", r), len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef LOADER_CHECKSUM_EN
    // Checksum good, then bad (sticky), then cleared by next START
    stim = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h00, 8'h00};
    run_load("t5_good", 2, 1'b0, 1'b0);
    run_load("t5_bad", 2, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("t5_err_sticky", 32'(bus.ERR_IL), 32'd1);
    stim.delete();
    run_load("t5_clear", 0, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
